// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared sizes, types and writeback source encoding for the writeback scheduler.
package regfile_wb_scheduler_pkg;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);
  localparam int DW   = 32;
  localparam int CW   = 2;

  typedef logic [AW-1:0] reg_idx_t;
  typedef logic [DW-1:0] data_t;
  typedef logic [CW-1:0] cnt_t;

  // Highest pending count a register may reach before issue is held.
  localparam cnt_t CNT_MAX = '1;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_src_e;
endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Issue and writeback-request bundle between the pipeline and the scheduler.
interface regfile_wb_scheduler_if import regfile_wb_scheduler_pkg::*; ();
  logic     iss_valid;
  reg_idx_t iss_rd;
  reg_idx_t iss_rs1;
  reg_idx_t iss_rs2;
  logic     iss_stall;

  logic     alu_valid;
  logic     alu_ready;
  reg_idx_t alu_rd;
  data_t    alu_data;

  logic     mem_valid;
  logic     mem_ready;
  reg_idx_t mem_rd;
  data_t    mem_data;

  modport master (
    output iss_valid, iss_rd, iss_rs1, iss_rs2,
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    input  iss_stall, alu_ready, mem_ready
  );

  modport slave (
    input  iss_valid, iss_rd, iss_rs1, iss_rs2,
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    output iss_stall, alu_ready, mem_ready
  );
endinterface

// File: rtl/regfile_wb_scheduler_rr_arbiter2.sv
// Two-requester round-robin arbiter; the pointer only moves after a contended grant.
module rr_arbiter2 import regfile_wb_scheduler_pkg::*; (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] req,
  output logic [1:0] grant
);
  wb_src_e ptr;

  // Uncontested requests pass straight through; a tie goes to the pointed source.
  always_comb begin
    grant = req;
    if (&req) grant = (ptr == WB_ALU) ? 2'b01 : 2'b10;
  end

  // Hand preference to the loser after every contended cycle.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)    ptr <= WB_ALU;
    else if (&req) ptr <= (ptr == WB_ALU) ? WB_MEM : WB_ALU;
  end
endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port owner: writeback arbitration, commit register and
// per-register pending-write scoreboard driving the issue stall.
module regfile_wb_scheduler import regfile_wb_scheduler_pkg::*; (
  input  logic                    CLK,
  input  logic                    RESET,
  regfile_wb_scheduler_if.slave   bus,
  output logic                    RegWrite,
  output reg_idx_t                WriteReg,
  output data_t                   WriteData,
  output logic [NREG-1:0]         busy_vec,
  output logic                    sb_err
);
  logic [1:0]      grant;
  logic            iss_fire;
  logic            err_nxt;
  logic [NREG-1:0] busy_eff;
  cnt_t            cnt     [NREG];
  cnt_t            cnt_nxt [NREG];

  rr_arbiter2 u_arb (
    .CLK   (CLK),
    .RESET (RESET),
    .req   ({bus.mem_valid, bus.alu_valid}),
    .grant (grant)
  );

  assign bus.alu_ready = grant[0];
  assign bus.mem_ready = grant[1];

  // Latch the granted request into the write port; x0 writes take the slot but never enable.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      RegWrite  <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
    end else if (grant[0]) begin
      RegWrite  <= (bus.alu_rd != '0);
      WriteReg  <= bus.alu_rd;
      WriteData <= bus.alu_data;
    end else if (grant[1]) begin
      RegWrite  <= (bus.mem_rd != '0);
      WriteReg  <= bus.mem_rd;
      WriteData <= bus.mem_data;
    end else begin
      RegWrite  <= 1'b0;
    end
  end

  assign iss_fire = bus.iss_valid & ~bus.iss_stall & (bus.iss_rd != '0);

  // Next pending counts: issue increments, commit decrements, both cancel; underflow is flagged.
  always_comb begin
    err_nxt = sb_err;
    for (int r = 0; r < NREG; r++) begin
      cnt_nxt[r] = cnt[r];
      if (r != 0) begin
        if (iss_fire && bus.iss_rd == reg_idx_t'(r) &&
            !(RegWrite && WriteReg == reg_idx_t'(r))) begin
          cnt_nxt[r] = cnt[r] + 1'b1;
        end else if (RegWrite && WriteReg == reg_idx_t'(r) &&
                     !(iss_fire && bus.iss_rd == reg_idx_t'(r))) begin
          if (cnt[r] == '0) err_nxt = 1'b1;
          else              cnt_nxt[r] = cnt[r] - 1'b1;
        end
      end else begin
        cnt_nxt[r] = '0;
      end
    end
  end

  // Scoreboard state, its registered busy view and the sticky error flag.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      busy_vec <= '0;
      sb_err   <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt[r]      <= cnt_nxt[r];
        busy_vec[r] <= (cnt_nxt[r] != '0);
      end
      sb_err <= err_nxt;
    end
  end

  // A register being committed this cycle is forwarded by the file, so it reads as ready.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      busy_eff[r] = (cnt[r] - cnt_t'(RegWrite && WriteReg == reg_idx_t'(r))) != '0;
    end
  end

  // Hold issue on RAW against pending sources, or when the destination count is full.
  always_comb begin
    bus.iss_stall = bus.iss_valid &
                    ((busy_eff[bus.iss_rs1] & (bus.iss_rs1 != '0)) |
                     (busy_eff[bus.iss_rs2] & (bus.iss_rs2 != '0)) |
                     ((cnt[bus.iss_rd] == CNT_MAX) & (bus.iss_rd != '0)));
  end
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: scoreboard, arbitration, x0, underflow, reset.
module tb_regfile_wb_scheduler;
  import regfile_wb_scheduler_pkg::*;

  logic            CLK = 1'b0;
  logic            RESET = 1'b0;
  logic            RegWrite;
  reg_idx_t        WriteReg;
  data_t           WriteData;
  logic [NREG-1:0] busy_vec;
  logic            sb_err;
  int              checks = 0;
  int              errors = 0;

  regfile_wb_scheduler_if bus ();

  regfile_wb_scheduler dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .bus       (bus),
    .RegWrite  (RegWrite),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .busy_vec  (busy_vec),
    .sb_err    (sb_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.iss_valid = 0; bus.iss_rd = 0; bus.iss_rs1 = 0; bus.iss_rs2 = 0;
    bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
    bus.mem_valid = 0; bus.mem_rd = 0; bus.mem_data = 0;

    // Power-on reset
    tick(); tick();
    chk("rst_regwrite", RegWrite, 0);
    chk("rst_writereg", WriteReg, 0);
    chk("rst_writedata", WriteData, 0);
    chk("rst_busy", busy_vec, 0);
    chk("rst_sberr", sb_err, 0);
    RESET = 1'b1;
    tick();

    // Reserve x3 and x4 through issue
    bus.iss_valid = 1; bus.iss_rd = 3; #1;
    chk("iss3_stall", bus.iss_stall, 0);
    tick();
    bus.iss_rd = 4; #1;
    chk("iss4_stall", bus.iss_stall, 0);
    tick();
    bus.iss_valid = 0; bus.iss_rd = 0;
    chk("busy_34", busy_vec, 32'h18);

    // Contention: ALU wins first, then pointer moves to MEM
    bus.alu_valid = 1; bus.alu_rd = 3; bus.alu_data = 32'hAAAA;
    bus.mem_valid = 1; bus.mem_rd = 4; bus.mem_data = 32'hBBBB; #1;
    chk("cont1_alu_ready", bus.alu_ready, 1);
    chk("cont1_mem_ready", bus.mem_ready, 0);
    tick();
    chk("cont1_regwrite", RegWrite, 1);
    chk("cont1_writereg", WriteReg, 3);
    chk("cont1_writedata", WriteData, 32'hAAAA);
    chk("cont2_alu_ready", bus.alu_ready, 0);
    chk("cont2_mem_ready", bus.mem_ready, 1);
    chk("cont2_busy", busy_vec, 32'h18);
    tick();
    bus.alu_valid = 0; bus.mem_valid = 0;
    chk("cont2_regwrite", RegWrite, 1);
    chk("cont2_writereg", WriteReg, 4);
    chk("cont2_writedata", WriteData, 32'hBBBB);
    chk("cont2_busy_after", busy_vec, 32'h10);
    tick();
    chk("idle_regwrite", RegWrite, 0);
    chk("idle_hold_reg", WriteReg, 4);
    chk("idle_hold_data", WriteData, 32'hBBBB);
    chk("idle_busy", busy_vec, 0);
    chk("idle_sberr", sb_err, 0);

    // RAW hazard on x5
    bus.iss_valid = 1; bus.iss_rd = 5; #1;
    chk("raw_issue_stall", bus.iss_stall, 0);
    tick();
    bus.iss_rd = 0; bus.iss_rs1 = 5; #1;
    chk("raw_stall1", bus.iss_stall, 1);
    tick();
    bus.alu_valid = 1; bus.alu_rd = 5; bus.alu_data = 32'h55; #1;
    chk("raw_stall2", bus.iss_stall, 1);
    chk("raw_alu_ready", bus.alu_ready, 1);
    tick();
    bus.alu_valid = 0;
    chk("raw_commit_regwrite", RegWrite, 1);
    chk("raw_commit_reg", WriteReg, 5);
    chk("raw_commit_stall", bus.iss_stall, 0);
    bus.iss_valid = 0; bus.iss_rs1 = 0;
    tick();
    chk("raw_busy_clear", busy_vec, 0);

    // Saturation of x7 (three outstanding writes)
    bus.iss_valid = 1; bus.iss_rd = 7;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("sat_issue_stall", bus.iss_stall, 0);
      tick();
    end
    chk("sat_busy", busy_vec, 32'h80);
    #1;
    chk("sat_stall4", bus.iss_stall, 1);
    bus.alu_valid = 1; bus.alu_rd = 7; bus.alu_data = 32'h7;
    tick();
    bus.alu_valid = 0;
    chk("sat_commit_regwrite", RegWrite, 1);
    chk("sat_commit_stall", bus.iss_stall, 1);
    tick();
    chk("sat_unstall", bus.iss_stall, 0);
    bus.iss_valid = 0; bus.iss_rd = 0;

    // x0 writeback consumes the slot without enabling a write
    bus.alu_valid = 1; bus.alu_rd = 0; bus.alu_data = 32'hFFFF; #1;
    chk("x0_alu_ready", bus.alu_ready, 1);
    chk("x0_mem_ready", bus.mem_ready, 0);
    tick();
    bus.alu_valid = 0;
    chk("x0_regwrite", RegWrite, 0);
    chk("x0_busy0", busy_vec[0], 0);
    chk("x0_busy", busy_vec, 32'h80);

    // Underflow: commit x9 with nothing pending
    bus.alu_valid = 1; bus.alu_rd = 9; bus.alu_data = 32'h9;
    tick();
    bus.alu_valid = 0;
    chk("uf_regwrite", RegWrite, 1);
    chk("uf_sberr_before", sb_err, 0);
    tick();
    chk("uf_sberr_set", sb_err, 1);
    tick(); tick();
    chk("uf_sberr_sticky", sb_err, 1);
    chk("uf_busy9", busy_vec[9], 0);

    // Asynchronous reset mid-stream with both sources valid
    bus.alu_valid = 1; bus.alu_rd = 10; bus.alu_data = 32'h1010;
    bus.mem_valid = 1; bus.mem_rd = 11; bus.mem_data = 32'h1111;
    tick();
    chk("mr_pre_regwrite", RegWrite, 1);
    chk("mr_pre_writereg", WriteReg, 10);
    #2 RESET = 1'b0;
    #1;
    chk("mr_async_regwrite", RegWrite, 0);
    chk("mr_async_sberr", sb_err, 0);
    tick();
    chk("mr_regwrite", RegWrite, 0);
    chk("mr_writereg", WriteReg, 0);
    chk("mr_writedata", WriteData, 0);
    chk("mr_busy", busy_vec, 0);
    chk("mr_sberr", sb_err, 0);
    RESET = 1'b1;
    bus.mem_valid = 0; bus.alu_valid = 0;
    tick();
    chk("post_regwrite", RegWrite, 0);
    chk("post_sberr", sb_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
